// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter in front of a single-port sync RAM.
// Define MEM_ARB_STARVE_EN to enable the fetch starvation counter; default is strict data priority.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        flush_i,
  output logic        hold_flag_o
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_D, WR_D} state_e;

  state_e state_q, state_d;
  logic   starve_win;

`ifdef MEM_ARB_STARVE_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Fetch overrides data once it has been denied STARVE_MAX cycles in a row.
  assign starve_win = (starve_cnt_q >= 4'(STARVE_MAX)) && if_req_i && !flush_i;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || flush_i || if_gnt_o)
      starve_cnt_d = '0;
    else if (starve_cnt_q != '1)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign starve_win        = 1'b0;
`endif

  assign d_gnt_o     = rst && d_req_i && !starve_win;
  assign if_gnt_o    = rst && if_req_i && !flush_i && !d_gnt_o;
  assign hold_flag_o = rst && if_req_i && !if_gnt_o;

  always_comb begin
    mem_en_o    = d_gnt_o || if_gnt_o;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    state_d     = IDLE;
    if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_we_o    = d_we_i ? d_be_i : 4'b0000;
      state_d     = d_we_i ? WR_D : RD_D;
    end else if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
      state_d    = RD_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Response side follows the access recorded last cycle; flush only kills fetch data.
  assign if_rvalid_o = rst && (state_q == RD_IF) && !flush_i;
  assign d_rvalid_o  = rst && (state_q == RD_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a request/response reference model.
module tb_mem_arbiter;
  localparam int unsigned SMAX = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_be_i, mem_we_o;
  logic        mem_en_o, flush_i, hold_flag_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .flush_i(flush_i), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: outstanding read responses (1 = fetch, 2 = data) and fetch denial streak.
  int resp_q[$];
  int streak = 0;
  int cyc_no = 0;
  int first_if_gnt = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit ir, input logic [31:0] ia, input bit dr,
                        input bit dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic [3:0] be, input logic [31:0] rd, input bit fl);
    rst = r; if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dw; d_addr_i = da;
    d_wdata_i = dd; d_be_i = be; mem_rdata_i = rd; flush_i = fl;
  endtask

  // Check all outputs for the current inputs, then advance one clock and update the model.
  task automatic cycle();
    bit win, eg_d, eg_i, ev_i, ev_d;
    int front;
    logic [31:0] ea;
    #2;
    front = (resp_q.size() > 0) ? resp_q[0] : 0;
    win  = STARVE_EN && streak >= int'(SMAX) && if_req_i && !flush_i;
    eg_d = rst && d_req_i && !win;
    eg_i = rst && if_req_i && !flush_i && !eg_d;
    ev_i = rst && front == 1 && !flush_i;
    ev_d = rst && front == 2;
    ea   = eg_d ? d_addr_i : (eg_i ? if_addr_i : 32'h0);
    chk("if_gnt", 32'(if_gnt_o), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt_o), 32'(eg_d));
    chk("hold_flag", 32'(hold_flag_o), 32'(rst && if_req_i && !eg_i));
    chk("mem_en", 32'(mem_en_o), 32'(eg_d || eg_i));
    chk("mem_we", 32'(mem_we_o), 32'((eg_d && d_we_i) ? d_be_i : 4'h0));
    chk("mem_addr", mem_addr_o, ea);
    if (!eg_i) chk("mem_wdata", mem_wdata_o, eg_d ? d_wdata_i : 32'h0);
    chk("if_rvalid", 32'(if_rvalid_o), 32'(ev_i));
    chk("d_rvalid", 32'(d_rvalid_o), 32'(ev_d));
    chk("if_rdata", if_rdata_o, ev_i ? mem_rdata_i : 32'h0);
    chk("d_rdata", d_rdata_o, ev_d ? mem_rdata_i : 32'h0);
    if (eg_i && first_if_gnt < 0) first_if_gnt = cyc_no;
    @(posedge clk);
    if (resp_q.size() > 0) void'(resp_q.pop_front());
    if (!rst) begin
      resp_q.delete();
      streak = 0;
    end else begin
      if (eg_i) resp_q.push_back(1);
      else if (eg_d && !d_we_i) resp_q.push_back(2);
      if (!if_req_i || flush_i || eg_i) streak = 0;
      else if (streak < 15) streak++;
    end
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic idle(input bit r);
    set_in(r, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, $urandom, 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset with active requests: everything must stay quiet.
    set_in(0, 1, 32'h40, 1, 1, 32'h80, 32'h1234, 4'hF, 32'hFFFF_FFFF, 0);
    cycle(); cycle();
    idle(1); cycle();

    // Fetch-only read of 0x10, RAM answers 0x13.
    set_in(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0); cycle();
    idle(1); mem_rdata_i = 32'h13; cycle();
    chk("fetch_rdata_13", if_rdata_o, 32'h0);

    // Simultaneous fetch and data load 0x100.
    set_in(1, 1, 32'h20, 1, 0, 32'h100, 32'h0, 4'hF, 32'h0, 0); cycle();
    set_in(1, 1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFE_0001, 0); cycle();
    idle(1); cycle();

    // Store 0x200, bytes 0-1.
    set_in(1, 0, 32'h0, 1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 32'h0, 0); cycle();
    idle(1); mem_rdata_i = 32'h5555_AAAA; cycle();

    // Data requesting every cycle with fetch pending.
    first_if_gnt = -1;
    cyc_no = 100;
    for (int i = 0; i < 7; i++) begin
      set_in(1, 1, 32'h30, 1, 0, 32'h300 + 32'(i), 32'h0, 4'hF, $urandom, 0);
      cycle();
    end
    if (STARVE_EN) chk("starve_fetch_cycle", 32'(first_if_gnt), 32'd104);
    else chk("no_starve_fetch", 32'(first_if_gnt), 32'hFFFF_FFFF);
    idle(1); cycle();

    // Flush during the fetch response cycle.
    set_in(1, 1, 32'h44, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0); cycle();
    set_in(1, 1, 32'h48, 0, 0, 32'h0, 32'h0, 4'h0, 32'h7777_0000, 1); cycle();
    set_in(1, 1, 32'h80, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0); cycle();
    idle(1); cycle();

    // Reset asserted during the data-read response cycle.
    set_in(1, 0, 32'h0, 1, 0, 32'h104, 32'h0, 4'hF, 32'h0, 0); cycle();
    set_in(0, 1, 32'h50, 1, 0, 32'h108, 32'h0, 4'hF, 32'h9999_9999, 0); cycle();
    idle(1); cycle();
    idle(1); cycle();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 39) != 0), $urandom_range(0, 3) != 0, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
             4'($urandom), $urandom, $urandom_range(0, 9) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive denied fetch-request cycles before fetch wins (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports if_req_i in 1, if_addr_i in 32: fetch request and word address.
REQ-005 SHALL have ports if_gnt_o out 1, if_rvalid_o out 1, if_rdata_o out 32: fetch grant, read-data valid, read data.
REQ-006 SHALL have ports d_req_i in 1, d_we_i in 1, d_addr_i in 32, d_wdata_i in 32, d_be_i in 4: load/store request.
REQ-007 SHALL have ports d_gnt_o out 1, d_rvalid_o out 1, d_rdata_o out 32: load/store grant, load-data valid, load data.
REQ-008 SHALL have ports mem_en_o out 1, mem_we_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_rdata_i in 32: single-port synchronous RAM, read latency 1.
REQ-009 SHALL have port flush_i in 1: jump taken, kills in-flight fetch data.
REQ-010 SHALL have port hold_flag_o out 1: fetch stalled, feeds pipeline hold.

Function
REQ-011 SHALL grant at most one requester per cycle; grant combinational in the request cycle.
REQ-012 SHALL grant data when d_req_i=1 unless the starvation rule applies; otherwise fetch when if_req_i=1.
REQ-013 SHALL, when starve_cnt reaches STARVE_MAX with if_req_i=1, grant fetch over data for exactly one cycle.
REQ-014 SHALL increment saturating starve_cnt (4 bits) each cycle if_req_i=1 and if_gnt_o=0; clear it on any fetch grant, flush_i=1, or if_req_i=0.
REQ-015 SHALL drive mem_* from the granted master: mem_en_o=1, mem_addr_o=address, mem_we_o=d_be_i if data write else 4'b0000, mem_wdata_o=d_wdata_i; mem_en_o=0 and all others 0 when no grant.
REQ-016 SHALL keep FSM state (IDLE, RD_IF, RD_D, WR_D) recording the access issued in the previous cycle.
REQ-017 SHALL transition each cycle to RD_IF on fetch grant, RD_D on data read grant, WR_D on data write grant, IDLE otherwise.
REQ-018 SHALL assert if_rvalid_o for one cycle in RD_IF and d_rvalid_o for one cycle in RD_D; never any rvalid in WR_D or IDLE.
REQ-019 SHALL route mem_rdata_i to the rdata of the rvalid master; the other rdata output is 0.
REQ-020 SHALL force if_rvalid_o=0 when flush_i=1 in the RD_IF cycle; data rvalid unaffected by flush_i.
REQ-021 SHALL not grant fetch in a cycle where flush_i=1 (new PC not yet presented).
REQ-022 SHALL drive hold_flag_o = if_req_i and not if_gnt_o, combinational.
REQ-023 SHALL allow back-to-back grants every cycle; pipelined throughput one access per cycle.
REQ-024 SHALL require requesters to hold req/address/data stable until granted; behaviour on withdrawal before grant is a dropped request, no memory access.

Reset
REQ-025 SHALL, while rst=0 at a clock edge, set state=IDLE and starve_cnt=0.
REQ-026 SHALL hold all grants, rvalids, rdata, mem_en_o, mem_we_o and hold_flag_o at 0 while rst=0 regardless of inputs.
REQ-027 SHALL discard any access in flight when reset is asserted mid-operation; no rvalid after reset release.

Configuration
REQ-028 SHALL, with macro MEM_ARB_STARVE_EN defined, implement starve_cnt and REQ-013/014.
REQ-029 SHALL, without MEM_ARB_STARVE_EN, use strict data priority, no counter, STARVE_MAX ignored.

Verification
REQ-030 SHALL cover: fetch-only read addr 0x0000_0010, mem returns 0x0000_0013 -> if_gnt_o same cycle, if_rvalid_o next cycle with 0x0000_0013.
REQ-031 SHALL cover: simultaneous fetch and data load 0x100 -> d_gnt_o=1, hold_flag_o=1; next cycle d_rvalid_o=1, if_gnt_o=1.
REQ-032 SHALL cover: data store 0x200, d_be_i=4'b0011, data 0xDEAD_BEEF -> mem_we_o=4'b0011, no rvalid next cycle.
REQ-033 SHALL cover (STARVE_EN, STARVE_MAX=4): data requesting every cycle with fetch pending -> fetch granted in 5th cycle, data regranted 6th.
REQ-034 SHALL cover: flush_i=1 in RD_IF cycle -> if_rvalid_o=0, starve_cnt=0, no fetch grant that cycle.
REQ-035 SHALL cover: rst=0 during RD_D cycle -> d_rvalid_o=0; all outputs 0 through first cycle after release with no requests.
